edp_muldiv_seq: RTL and testbench

//  Step sequencer for EDP multiply/divide. Sequences the EDP adder, AR/ARX load and MQ shift once per cycle.

---
 rtl/edp_muldiv_seq.sv | 172 +++++++++++++++++
 tb/tb_edp_muldiv_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edp_muldiv_seq.sv
// Step sequencer for EDP multiply/divide: radix-4 Booth multiply and non-restoring divide.
// Drives adder function, AR/ARX load and MQ shift control broadcast to all EDP slices.
module edp_muldiv_seq #(
   parameter int MUL_STEPS = 18,
   parameter int DIV_STEPS = 36,
   parameter int CNT_W     = 6
) (
   input  logic             clk_edp_h,
   input  logic             mr_reset_l,
   input  logic             start_h,
   input  logic             op_div_h,
   input  logic             abort_h,
   input  logic             div_ovf_h,
   input  logic             mq_34_h,
   input  logic             mq_35_h,
   input  logic             ad_00_h,
   output logic             busy_h,
   output logic             done_h,
   output logic             ovf_h,
   output logic [2:0]       ad_func_h,
   output logic             ar_load_h,
   output logic [1:0]       mq_sel_h,
   output logic             q_bit_h,
   output logic [CNT_W-1:0] step_cnt_h
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STEP,
      S_FIXUP,
      S_DONE
   } state_t;

   localparam logic [2:0] AD_PASS  = 3'd0;
   localparam logic [2:0] AD_ADD   = 3'd1;
   localparam logic [2:0] AD_SUB   = 3'd2;
   localparam logic [2:0] AD_ADD2  = 3'd3;
   localparam logic [2:0] AD_SUB2  = 3'd4;

   localparam logic [1:0] MQ_HOLD  = 2'd0;
   localparam logic [1:0] MQ_SHR2  = 2'd1;
   localparam logic [1:0] MQ_SHL1  = 2'd2;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_STEPS);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_STEPS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             booth_cry_q, booth_cry_d;
   logic             op_div_q, op_div_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge clk_edp_h or negedge mr_reset_l) begin
      if (!mr_reset_l) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         booth_cry_q <= 1'b0;
         op_div_q    <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         booth_cry_q <= booth_cry_d;
         op_div_q    <= op_div_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      booth_cry_d = booth_cry_q;
      op_div_d    = op_div_q;
      ovf_d       = ovf_q;
      busy_h      = 1'b0;
      done_h      = 1'b0;
      ovf_h       = 1'b0;
      ad_func_h   = AD_PASS;
      ar_load_h   = 1'b0;
      mq_sel_h    = MQ_HOLD;
      q_bit_h     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_h) begin
               state_d  = S_SETUP;
               op_div_d = op_div_h;
            end
         end

         S_SETUP: begin
            busy_h      = 1'b1;
            cnt_d       = op_div_q ? DIV_CNT : MUL_CNT;
            booth_cry_d = 1'b0;
            if (op_div_q && div_ovf_h) begin
               ovf_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_STEP;
            end
         end

         S_STEP: begin
            busy_h    = 1'b1;
            ar_load_h = 1'b1;
            cnt_d     = cnt_q - CNT_ONE;
            if (op_div_q) begin
               mq_sel_h = MQ_SHL1;
               q_bit_h  = ~ad_00_h;
               // The first divide step always subtracts; later steps restore by sign.
               if ((cnt_q == DIV_CNT) || !ad_00_h) begin
                  ad_func_h = AD_SUB;
               end else begin
                  ad_func_h = AD_ADD;
               end
            end else begin
               mq_sel_h    = MQ_SHR2;
               booth_cry_d = mq_34_h;
               case ({mq_34_h, mq_35_h, booth_cry_q})
                  3'b001, 3'b010: ad_func_h = AD_ADD;
                  3'b011:         ad_func_h = AD_ADD2;
                  3'b100:         ad_func_h = AD_SUB2;
                  3'b101, 3'b110: ad_func_h = AD_SUB;
                  default:        ad_func_h = AD_PASS;
               endcase
            end
            if (cnt_q == CNT_ONE) begin
               state_d = (op_div_q && ad_00_h) ? S_FIXUP : S_DONE;
            end
         end

         S_FIXUP: begin
            busy_h    = 1'b1;
            ad_func_h = AD_ADD;
            ar_load_h = 1'b1;
            state_d   = S_DONE;
         end

         S_DONE: begin
            busy_h  = 1'b1;
            done_h  = 1'b1;
            ovf_h   = ovf_q;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything, including the outputs of the current cycle.
      if (abort_h) begin
         state_d     = S_IDLE;
         cnt_d       = '0;
         booth_cry_d = 1'b0;
         ovf_d       = 1'b0;
         busy_h      = 1'b0;
         done_h      = 1'b0;
         ovf_h       = 1'b0;
         ad_func_h   = AD_PASS;
         ar_load_h   = 1'b0;
         mq_sel_h    = MQ_HOLD;
         q_bit_h     = 1'b0;
      end
   end

   assign step_cnt_h = cnt_q;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Directed self-checking bench for edp_muldiv_seq: Booth multiply, divide with and
// without fixup, divide overflow, abort, back-to-back start and async reset.
module tb_edp_muldiv_seq;

   logic       clk_edp_h;
   logic       mr_reset_l;
   logic       start_h;
   logic       op_div_h;
   logic       abort_h;
   logic       div_ovf_h;
   logic       mq_34_h;
   logic       mq_35_h;
   logic       ad_00_h;
   logic       busy_h;
   logic       done_h;
   logic       ovf_h;
   logic [2:0] ad_func_h;
   logic       ar_load_h;
   logic [1:0] mq_sel_h;
   logic       q_bit_h;
   logic [5:0] step_cnt_h;

   int checks = 0;
   int errors = 0;

   // Hand-decoded Booth streams: multiplier pairs and the adder function each step yields.
   localparam logic [1:0] P0_MQ [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   localparam logic [2:0] P0_FN [4] = '{3'd1,  3'd2,  3'd2,  3'd1};
   localparam logic [1:0] P1_MQ [6] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
   localparam logic [2:0] P1_FN [6] = '{3'd4,  3'd3,  3'd2,  3'd0,  3'd1,  3'd0};

   edp_muldiv_seq #(.MUL_STEPS(18), .DIV_STEPS(36), .CNT_W(6)) dut (
      .clk_edp_h  (clk_edp_h),
      .mr_reset_l (mr_reset_l),
      .start_h    (start_h),
      .op_div_h   (op_div_h),
      .abort_h    (abort_h),
      .div_ovf_h  (div_ovf_h),
      .mq_34_h    (mq_34_h),
      .mq_35_h    (mq_35_h),
      .ad_00_h    (ad_00_h),
      .busy_h     (busy_h),
      .done_h     (done_h),
      .ovf_h      (ovf_h),
      .ad_func_h  (ad_func_h),
      .ar_load_h  (ar_load_h),
      .mq_sel_h   (mq_sel_h),
      .q_bit_h    (q_bit_h),
      .step_cnt_h (step_cnt_h)
   );

   initial clk_edp_h = 1'b0;
   always #5 clk_edp_h = ~clk_edp_h;

   task automatic tick();
      @(posedge clk_edp_h);
      #1;
   endtask

   task automatic test_reset();
      mr_reset_l = 1'b0;
      start_h = 0; op_div_h = 0; abort_h = 0; div_ovf_h = 0;
      mq_34_h = 0; mq_35_h = 0; ad_00_h = 0;
      #12;
      checks++;
      if ({busy_h, done_h, ovf_h, ad_func_h, ar_load_h, mq_sel_h, q_bit_h, step_cnt_h} !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs busy=%b done=%b ovf=%b func=%0d load=%b sel=%0d q=%b cnt=%0d expected all 0",
                  busy_h, done_h, ovf_h, ad_func_h, ar_load_h, mq_sel_h, q_bit_h, step_cnt_h);
      end
      mr_reset_l = 1'b1;
      tick();
   endtask

   task automatic run_mul(input int pat, input bit start_mid);
      int         loads;
      logic [1:0] mq;
      logic [2:0] expf;
      start_h = 1; op_div_h = 0;
      tick();
      start_h = 0;
      #1;
      checks++;
      if (busy_h !== 1'b1 || ar_load_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mul_setup busy=%b load=%b expected busy=1 load=0", busy_h, ar_load_h);
      end
      tick();
      loads = 0;
      for (int i = 0; i < 18; i++) begin
         if (pat == 0) begin
            mq = P0_MQ[i % 4]; expf = P0_FN[i % 4];
         end else begin
            mq = P1_MQ[i % 6]; expf = P1_FN[i % 6];
         end
         {mq_34_h, mq_35_h} = mq;
         start_h = start_mid;
         #1;
         checks++;
         if (ad_func_h !== expf) begin
            errors++;
            $display("[TB] FAIL mul_func step=%0d got=%0d expected=%0d", i, ad_func_h, expf);
         end
         checks++;
         if (step_cnt_h !== 6'(18 - i) || mq_sel_h !== 2'd1 || done_h !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mul_step step=%0d cnt=%0d sel=%0d done=%b expected cnt=%0d sel=1 done=0",
                     i, step_cnt_h, mq_sel_h, done_h, 18 - i);
         end
         if (ar_load_h) loads++;
         tick();
      end
      start_h = 0; mq_34_h = 0; mq_35_h = 0;
      #1;
      checks++;
      if (loads !== 18) begin
         errors++;
         $display("[TB] FAIL mul_loads got=%0d expected=18", loads);
      end
      checks++;
      if (done_h !== 1'b1 || ovf_h !== 1'b0 || ar_load_h !== 1'b0 || step_cnt_h !== 6'd0) begin
         errors++;
         $display("[TB] FAIL mul_done_c20 done=%b ovf=%b load=%b cnt=%0d expected done=1 ovf=0 load=0 cnt=0",
                  done_h, ovf_h, ar_load_h, step_cnt_h);
      end
      tick();
      checks++;
      if (busy_h !== 1'b0 || done_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mul_idle busy=%b done=%b expected 0 0", busy_h, done_h);
      end
   endtask

   task automatic test_mul_basic();
      run_mul(0, 1'b0);
   endtask

   task automatic test_mul_start_ignored();
      run_mul(1, 1'b1);
   endtask

   task automatic test_div(input bit fix);
      logic       ad;
      logic [2:0] expf;
      start_h = 1; op_div_h = 1;
      tick();
      start_h = 0; op_div_h = 0; div_ovf_h = 0;
      #1;
      checks++;
      if (busy_h !== 1'b1 || ar_load_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL div_setup busy=%b load=%b expected busy=1 load=0", busy_h, ar_load_h);
      end
      tick();
      for (int i = 0; i < 36; i++) begin
         ad = (i == 35) ? fix : ((i % 3) == 0);
         ad_00_h = ad;
         #1;
         expf = (i == 0 || !ad) ? 3'd2 : 3'd1;
         checks++;
         if (ad_func_h !== expf || q_bit_h !== ~ad) begin
            errors++;
            $display("[TB] FAIL div_step step=%0d func=%0d q=%b expected func=%0d q=%b",
                     i, ad_func_h, q_bit_h, expf, ~ad);
         end
         checks++;
         if (mq_sel_h !== 2'd2 || ar_load_h !== 1'b1 || done_h !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_ctl step=%0d sel=%0d load=%b done=%b expected sel=2 load=1 done=0",
                     i, mq_sel_h, ar_load_h, done_h);
         end
         tick();
      end
      ad_00_h = 0;
      #1;
      if (fix) begin
         checks++;
         if (ad_func_h !== 3'd1 || ar_load_h !== 1'b1 || mq_sel_h !== 2'd0 || done_h !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div_fixup func=%0d load=%b sel=%0d done=%b expected func=1 load=1 sel=0 done=0",
                     ad_func_h, ar_load_h, mq_sel_h, done_h);
         end
         tick();
      end
      checks++;
      if (done_h !== 1'b1 || ovf_h !== 1'b0 || ar_load_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL div_done fix=%b done=%b ovf=%b load=%b expected done=1 ovf=0 load=0",
                  fix, done_h, ovf_h, ar_load_h);
      end
      tick();
   endtask

   task automatic test_div_ovf();
      start_h = 1; op_div_h = 1;
      tick();
      start_h = 0; op_div_h = 0; div_ovf_h = 1;
      #1;
      checks++;
      if (ar_load_h !== 1'b0 || done_h !== 1'b0 || busy_h !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_setup load=%b done=%b busy=%b expected 0 0 1", ar_load_h, done_h, busy_h);
      end
      tick();
      div_ovf_h = 0;
      #1;
      checks++;
      if (done_h !== 1'b1 || ovf_h !== 1'b1 || ar_load_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_done_c2 done=%b ovf=%b load=%b expected 1 1 0", done_h, ovf_h, ar_load_h);
      end
      tick();
      checks++;
      if (busy_h !== 1'b0 || ovf_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_clear busy=%b ovf=%b expected 0 0", busy_h, ovf_h);
      end
   endtask

   task automatic test_abort();
      int  cyc;
      bit  seen;
      start_h = 1; op_div_h = 0; mq_34_h = 0; mq_35_h = 1;
      tick();
      start_h = 0;
      tick();
      for (int i = 0; i < 6; i++) tick();
      abort_h = 1;
      #1;
      checks++;
      if (ar_load_h !== 1'b0 || ad_func_h !== 3'd0 || mq_sel_h !== 2'd0) begin
         errors++;
         $display("[TB] FAIL abort_same_cycle load=%b func=%0d sel=%0d expected 0 0 0", ar_load_h, ad_func_h, mq_sel_h);
      end
      tick();
      abort_h = 0;
      #1;
      checks++;
      if (busy_h !== 1'b0 || step_cnt_h !== 6'd0) begin
         errors++;
         $display("[TB] FAIL abort_idle busy=%b cnt=%0d expected 0 0", busy_h, step_cnt_h);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         if (done_h) seen = 1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_no_done saw done_h=1 expected none");
      end
      // Abort together with start in IDLE must keep the sequencer idle.
      start_h = 1; abort_h = 1;
      tick();
      start_h = 0; abort_h = 0;
      #1;
      checks++;
      if (busy_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_start_idle busy=%b expected 0", busy_h);
      end
      start_h = 1;
      tick();
      start_h = 0;
      cyc = 1;
      while (!done_h && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc !== 20 || done_h !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_restart_latency got=%0d done=%b expected=20 done=1", cyc, done_h);
      end
      tick();
      mq_35_h = 0;
   endtask

   task automatic test_back_to_back();
      int cyc;
      start_h = 1; op_div_h = 0; mq_34_h = 0; mq_35_h = 0;
      tick();
      cyc = 1;
      while (!done_h && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (done_h !== 1'b1 || cyc !== 20) begin
         errors++;
         $display("[TB] FAIL b2b_first_done cyc=%0d done=%b expected 20 1", cyc, done_h);
      end
      tick();
      checks++;
      if (busy_h !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_idle busy=%b expected 0", busy_h);
      end
      tick();
      start_h = 0;
      checks++;
      if (busy_h !== 1'b1 || step_cnt_h !== 6'd0) begin
         errors++;
         $display("[TB] FAIL b2b_restart busy=%b cnt=%0d expected 1 0", busy_h, step_cnt_h);
      end
      cyc = 1;
      while (!done_h && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (done_h !== 1'b1 || cyc !== 20) begin
         errors++;
         $display("[TB] FAIL b2b_second_done cyc=%0d done=%b expected 20 1", cyc, done_h);
      end
      tick();
   endtask

   task automatic test_reset_mid_step();
      start_h = 1; op_div_h = 0;
      tick();
      start_h = 0;
      tick();
      tick();
      tick();
      mq_34_h = 0; mq_35_h = 1;
      #1;
      checks++;
      if (ad_func_h !== 3'd1 || busy_h !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_step func=%0d busy=%b expected 1 1", ad_func_h, busy_h);
      end
      mr_reset_l = 0;
      #1;
      checks++;
      if (busy_h !== 1'b0 || ad_func_h !== 3'd0 || ar_load_h !== 1'b0 || step_cnt_h !== 6'd0) begin
         errors++;
         $display("[TB] FAIL async_reset busy=%b func=%0d load=%b cnt=%0d expected 0 0 0 0",
                  busy_h, ad_func_h, ar_load_h, step_cnt_h);
      end
      #1;
      mr_reset_l = 1;
      mq_35_h = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_mul_start_ignored();
      test_div(1'b1);
      test_div(1'b0);
      test_div_ovf();
      test_abort();
      test_back_to_back();
      test_reset_mid_step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
